// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the EX-stage branch resolution / PC redirect controller.
// Comparator select codes follow the RV32I branch funct3 encoding.
package branch_ctrl_pkg;

    localparam logic [2:0] BR_UNIT_SEL_BEQ  = 3'b000;
    localparam logic [2:0] BR_UNIT_SEL_BNE  = 3'b001;
    localparam logic [2:0] BR_UNIT_SEL_BLT  = 3'b100;
    localparam logic [2:0] BR_UNIT_SEL_BGE  = 3'b101;
    localparam logic [2:0] BR_UNIT_SEL_BLTU = 3'b110;
    localparam logic [2:0] BR_UNIT_SEL_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BRC_ST_IDLE  = 2'd0,
        BRC_ST_PEND  = 2'd1,
        BRC_ST_FLUSH = 2'd2
    } brc_state_t;

    // Only 4-byte instruction alignment is checked; JALR already clears bit 0.
    function automatic logic target_misaligned(input logic [31:0] target);
        return target[1];
    endfunction

endpackage

// File: rtl/branch_ctrl_br_unit.sv
// Branch comparator: evaluates the condition selected by sel on two operands.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module branch_ctrl_br_unit
    import branch_ctrl_pkg::*;
(
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [2:0]  sel,
    output logic        br_en
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_data == rs2_data);
    assign lt_s = ($signed(rs1_data) < $signed(rs2_data));
    assign lt_u = (rs1_data < rs2_data);

    always_comb begin
        br_en = 1'b0;
        case (sel)
            BR_UNIT_SEL_BEQ:  br_en = eq;
            BR_UNIT_SEL_BNE:  br_en = !eq;
            BR_UNIT_SEL_BLT:  br_en = lt_s;
            BR_UNIT_SEL_BGE:  br_en = !lt_s;
            BR_UNIT_SEL_BLTU: br_en = lt_u;
            BR_UNIT_SEL_BGEU: br_en = !lt_u;
            default:          br_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage control-transfer sequencer: resolves branches/jumps, traps and MRET into a held PC redirect.
// Latency: redirect, flushes and misalign pulse are registered, visible one cycle after resolution.
// Backpressure: redirect held in PEND until fetch_ready; busy stalls upstream issue outside IDLE.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic [2:0]  ex_br_sel,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        stall_in,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    input  logic        mret_req,
    input  logic [31:0] mepc,
    input  logic        fetch_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        busy,
    output logic        misalign_exc
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    brc_state_t  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        rv_q, rv_d;
    logic        flush_q, flush_d;
    logic        mis_q, mis_d;

    logic        br_en;
    logic        ex_take;
    logic [31:0] ex_target;

    branch_ctrl_br_unit u_br_unit (
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .sel      (ex_br_sel),
        .br_en    (br_en)
    );

    assign ex_take = ex_valid & !stall_in &
                     ((ex_is_br & br_en) | ex_is_jal | ex_is_jalr);
    assign ex_target = ex_is_jalr ? ((rs1_data + ex_imm) & ~32'h1)
                                  : (ex_pc + ex_imm);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
        case (state_q)
            BRC_ST_IDLE: begin
                if (trap_req) begin
                    pc_d    = trap_vec;
                    state_d = BRC_ST_PEND;
                end else if (mret_req) begin
                    pc_d    = mepc;
                    state_d = BRC_ST_PEND;
                end else if (ex_take) begin
                    // Misaligned targets never redirect; the CSR block follows up with a trap.
                    if (target_misaligned(ex_target)) begin
                        mis_d = 1'b1;
                    end else begin
                        pc_d    = ex_target;
                        state_d = BRC_ST_PEND;
                    end
                end
            end
            BRC_ST_PEND: begin
                if (trap_req) begin
                    pc_d = trap_vec;
                end else if (fetch_ready) begin
                    cnt_d   = FLUSH_INIT;
                    state_d = BRC_ST_FLUSH;
                end
            end
            BRC_ST_FLUSH: begin
                if (trap_req) begin
                    pc_d    = trap_vec;
                    state_d = BRC_ST_PEND;
                end else if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = BRC_ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = BRC_ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
        rv_d    = (state_d == BRC_ST_PEND);
        flush_d = (state_d != BRC_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BRC_ST_IDLE;
            cnt_q   <= 2'd0;
            pc_q    <= RESET_PC;
            rv_q    <= 1'b0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            rv_q    <= rv_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

    assign redirect_valid = rv_q;
    assign redirect_pc    = pc_q;
    assign flush_if       = flush_q;
    assign flush_id       = flush_q;
    assign busy           = (state_q != BRC_ST_IDLE);
    assign misalign_exc   = mis_q;

endmodule
